// File: rtl/regbank_access_ctrl.sv
// regbank_access_ctrl
//   Sequences every access to the dual-address 32x32 register bank.
//   A writeback requester (one or two destinations) and an operand-fetch
//   requester (two sources) are arbitrated in IDLE. Write wins by default,
//   but after MAX_WR_STREAK consecutive write grants with a read waiting, the
//   read is granted so it cannot starve. Register 0 is never written and
//   always reads as zero.
//
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   wr_valid/wr_ready            write handshake (ready only in IDLE)
//   wr_dual                      1: write A and B, 0: write A only
//   wr_addr_a/b, wr_data_a/b     write destinations and data
//   rd_valid/rd_ready            read handshake (ready only in IDLE)
//   rd_addr_a/b                  read sources
//   rsp_valid, rsp_data_a/b      one-cycle response pulse and held read data
//   bank_address/bank_addressB   bank address ports
//   bank_enable_write/_read      bank enables
//   bank_in_data/bank_in_dataB   bank write data
//   bank_out_data/bank_out_dataB bank read data (only sampled in RD_CAPTURE)
module regbank_access_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned MAX_WR_STREAK = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_dual,
    input  logic [ADDR_WIDTH-1:0] wr_addr_a,
    input  logic [ADDR_WIDTH-1:0] wr_addr_b,
    input  logic [DATA_WIDTH-1:0] wr_data_a,
    input  logic [DATA_WIDTH-1:0] wr_data_b,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data_a,
    output logic [DATA_WIDTH-1:0] rsp_data_b,
    output logic [ADDR_WIDTH-1:0] bank_address,
    output logic [ADDR_WIDTH-1:0] bank_addressB,
    output logic                  bank_enable_write,
    output logic                  bank_enable_read,
    output logic [DATA_WIDTH-1:0] bank_in_data,
    output logic [DATA_WIDTH-1:0] bank_in_dataB,
    input  logic [DATA_WIDTH-1:0] bank_out_data,
    input  logic [DATA_WIDTH-1:0] bank_out_dataB
);

    localparam int unsigned         STREAK_W   = $clog2(MAX_WR_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_CAPTURE
    } state_t;

    state_t                state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d;
    logic [DATA_WIDTH-1:0] wdata_b_q, wdata_b_d;
    logic                  wen_q, wen_d;
    logic                  ren_q, ren_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_a_q, rsp_a_d;
    logic [DATA_WIDTH-1:0] rsp_b_q, rsp_b_d;
    logic                  wr_grant, rd_grant;

    // Write has priority unless the streak limit is hit with a read waiting.
    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (state_q == IDLE) begin
            if (wr_valid && !(rd_valid && streak_q == STREAK_MAX)) begin
                wr_grant = 1'b1;
            end else if (rd_valid) begin
                rd_grant = 1'b1;
            end
        end
    end

    // state_q already reads IDLE during reset; gate so readies are 0 too.
    assign wr_ready = reset & wr_grant;
    assign rd_ready = reset & rd_grant;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        wdata_a_d   = wdata_a_q;
        wdata_b_d   = wdata_b_q;
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;

        unique case (state_q)
            IDLE: begin
                if (wr_grant) begin
                    state_d = WR_ISSUE;
                    if (!rd_valid) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                    // The bank writes both ports, so a skipped or shadowed
                    // destination is replaced by the surviving one.
                    wen_d = wr_dual ? (wr_addr_a != '0 || wr_addr_b != '0)
                                    : (wr_addr_a != '0);
                    if (!wr_dual || wr_addr_b == '0) begin
                        addr_a_d  = wr_addr_a;
                        addr_b_d  = wr_addr_a;
                        wdata_a_d = wr_data_a;
                        wdata_b_d = wr_data_a;
                    end else if (wr_addr_a == '0 || wr_addr_a == wr_addr_b) begin
                        addr_a_d  = wr_addr_b;
                        addr_b_d  = wr_addr_b;
                        wdata_a_d = wr_data_b;
                        wdata_b_d = wr_data_b;
                    end else begin
                        addr_a_d  = wr_addr_a;
                        addr_b_d  = wr_addr_b;
                        wdata_a_d = wr_data_a;
                        wdata_b_d = wr_data_b;
                    end
                end else if (rd_grant) begin
                    state_d  = RD_ISSUE;
                    streak_d = '0;
                    addr_a_d = rd_addr_a;
                    addr_b_d = rd_addr_b;
                    ren_d    = 1'b1;
                end else if (!rd_valid) begin
                    streak_d = '0;
                end
            end
            WR_ISSUE: begin
                state_d = IDLE;
            end
            RD_ISSUE: begin
                state_d = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                // Addresses are still held from the read grant.
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_a_d     = (addr_a_q == '0) ? '0 : bank_out_data;
                rsp_b_d     = (addr_b_q == '0) ? '0 : bank_out_dataB;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            wdata_a_q   <= '0;
            wdata_b_q   <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            wdata_a_q   <= wdata_a_d;
            wdata_b_q   <= wdata_b_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
        end
    end

    assign bank_address      = addr_a_q;
    assign bank_addressB     = addr_b_q;
    assign bank_in_data      = wdata_a_q;
    assign bank_in_dataB     = wdata_b_q;
    assign bank_enable_write = wen_q;
    assign bank_enable_read  = ren_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data_a        = rsp_a_q;
    assign rsp_data_b        = rsp_b_q;

endmodule

// File: tb/tb_regbank_access_ctrl.sv
module tb_regbank_access_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        wr_dual = 1'b0;
    logic [4:0]  wr_addr_a = '0;
    logic [4:0]  wr_addr_b = '0;
    logic [31:0] wr_data_a = '0;
    logic [31:0] wr_data_b = '0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [4:0]  rd_addr_a = '0;
    logic [4:0]  rd_addr_b = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data_a, rsp_data_b;
    logic [4:0]  bank_address, bank_addressB;
    logic        bank_enable_write, bank_enable_read;
    logic [31:0] bank_in_data, bank_in_dataB;
    logic [31:0] bank_out_data, bank_out_dataB;

    int n_err = 0;
    int n_chk = 0;

    always #5 clock = ~clock;

    regbank_access_ctrl #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (5),
        .MAX_WR_STREAK(4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_dual          (wr_dual),
        .wr_addr_a        (wr_addr_a),
        .wr_addr_b        (wr_addr_b),
        .wr_data_a        (wr_data_a),
        .wr_data_b        (wr_data_b),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_addr_a        (rd_addr_a),
        .rd_addr_b        (rd_addr_b),
        .rsp_valid        (rsp_valid),
        .rsp_data_a       (rsp_data_a),
        .rsp_data_b       (rsp_data_b),
        .bank_address     (bank_address),
        .bank_addressB    (bank_addressB),
        .bank_enable_write(bank_enable_write),
        .bank_enable_read (bank_enable_read),
        .bank_in_data     (bank_in_data),
        .bank_in_dataB    (bank_in_dataB),
        .bank_out_data    (bank_out_data),
        .bank_out_dataB   (bank_out_dataB)
    );

    // Behavioural register bank: writes both ports on enable_write, latches
    // its output registers on enable_read. Preloaded with a pattern so r0
    // holds a nonzero value that the controller must mask.
    logic [31:0] mem [32];
    logic [31:0] out_a_q, out_b_q;
    logic        mem_init = 1'b0;

    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem_init <= 1'b1;
        end else if (bank_enable_write) begin
            mem[bank_address]  <= bank_in_data;
            mem[bank_addressB] <= bank_in_dataB;
        end
        if (bank_enable_read && mem_init) begin
            out_a_q <= mem[bank_address];
            out_b_q <= mem[bank_addressB];
        end
    end
    assign bank_out_data  = out_a_q;
    assign bank_out_dataB = out_b_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Starts and ends at posedge+1 in an IDLE cycle.
    task automatic do_write(input logic dual, input logic [4:0] a, input logic [4:0] b,
                            input logic [31:0] da, input logic [31:0] db,
                            input logic en, input logic [4:0] ea, input logic [4:0] eb,
                            input logic [31:0] ed, input logic [31:0] edb);
        wr_valid = 1'b1; wr_dual = dual;
        wr_addr_a = a; wr_addr_b = b; wr_data_a = da; wr_data_b = db;
        #1;
        chk("wr_ready", 32'(wr_ready), 32'd1);
        chk("rd_ready_in_wr", 32'(rd_ready), 32'd0);
        @(posedge clock); #1;
        wr_valid = 1'b0;
        chk("wr_issue_we", 32'(bank_enable_write), 32'(en));
        chk("wr_issue_re", 32'(bank_enable_read), 32'd0);
        if (en) begin
            chk("wr_addr", 32'(bank_address), 32'(ea));
            chk("wr_addrB", 32'(bank_addressB), 32'(eb));
            chk("wr_data", bank_in_data, ed);
            chk("wr_dataB", bank_in_dataB, edb);
        end
        @(posedge clock); #1;
        chk("wr_we_drop", 32'(bank_enable_write), 32'd0);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                           input logic [31:0] ea, input logic [31:0] eb);
        rd_valid = 1'b1; rd_addr_a = a; rd_addr_b = b;
        #1;
        chk("rd_ready", 32'(rd_ready), 32'd1);
        chk("wr_ready_in_rd", 32'(wr_ready), 32'd0);
        @(posedge clock); #1;
        rd_valid = 1'b0;
        chk("rd_issue_re", 32'(bank_enable_read), 32'd1);
        chk("rd_issue_we", 32'(bank_enable_write), 32'd0);
        chk("rd_issue_addr", 32'(bank_address), 32'(a));
        chk("rd_issue_addrB", 32'(bank_addressB), 32'(b));
        @(posedge clock); #1;
        chk("rd_capture_re", 32'(bank_enable_read), 32'd0);
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        @(posedge clock); #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_a", rsp_data_a, ea);
        chk("rsp_b", rsp_data_b, eb);
        @(posedge clock); #1;
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("rsp_a_hold", rsp_data_a, ea);
    endtask

    typedef struct {
        bit          is_wr;
        bit          dual;
        logic [4:0]  a, b;
        logic [31:0] da, db;
        bit          en;
        logic [4:0]  ea, eb;
        logic [31:0] ed, edb;   // write: expected bank data; read: expected rsp
    } vec_t;

    function automatic vec_t wv(bit dual, logic [4:0] a, logic [31:0] da, logic [4:0] b,
                                logic [31:0] db, bit en, logic [4:0] ea, logic [4:0] eb,
                                logic [31:0] ed, logic [31:0] edb);
        vec_t v;
        v.is_wr = 1'b1; v.dual = dual; v.a = a; v.b = b; v.da = da; v.db = db;
        v.en = en; v.ea = ea; v.eb = eb; v.ed = ed; v.edb = edb;
        return v;
    endfunction

    function automatic vec_t rv(logic [4:0] a, logic [4:0] b, logic [31:0] ea, logic [31:0] eb);
        vec_t v;
        v = '{default: '0};
        v.is_wr = 1'b0; v.a = a; v.b = b; v.ed = ea; v.edb = eb;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        bit          rec_rd [20];
        int          n_grants;
        int          n_rsp;
        logic [31:0] last_wr;
        logic [31:0] exp_rsp;
        bit          wgrant;

        vecs[0]  = wv(0, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,  1, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF);
        vecs[1]  = rv(5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
        vecs[2]  = wv(1, 5'd3,  32'h11, 5'd0,  32'h22, 1, 5'd3,  5'd3,  32'h11, 32'h11);
        vecs[3]  = rv(5'd3, 5'd0, 32'h11, 32'h0);
        vecs[4]  = wv(1, 5'd7,  32'hAA, 5'd7,  32'hBB, 1, 5'd7,  5'd7,  32'hBB, 32'hBB);
        vecs[5]  = rv(5'd7, 5'd7, 32'hBB, 32'hBB);
        vecs[6]  = wv(1, 5'd0,  32'h55, 5'd12, 32'h66, 1, 5'd12, 5'd12, 32'h66, 32'h66);
        vecs[7]  = wv(1, 5'd20, 32'h77, 5'd21, 32'h88, 1, 5'd20, 5'd21, 32'h77, 32'h88);
        vecs[8]  = rv(5'd20, 5'd21, 32'h77, 32'h88);
        vecs[9]  = rv(5'd12, 5'd4, 32'h66, 32'hA500_0004);
        vecs[10] = wv(0, 5'd0,  32'h99, 5'd6,  32'h0,  0, 5'd0,  5'd0,  32'h0, 32'h0);
        vecs[11] = wv(1, 5'd0,  32'h98, 5'd0,  32'h97, 0, 5'd0,  5'd0,  32'h0, 32'h0);
        vecs[12] = rv(5'd0, 5'd5, 32'h0, 32'hDEADBEEF);
        vecs[13] = wv(0, 5'd9,  32'h1234, 5'd0, 32'h0, 1, 5'd9,  5'd9,  32'h1234, 32'h1234);
        vecs[14] = rv(5'd9, 5'd0, 32'h1234, 32'h0);   // issued in the very next IDLE cycle
        vecs[15] = rv(5'd0, 5'd0, 32'h0, 32'h0);

        // Reset state, with both requests asserted to expose ungated readies.
        wr_valid = 1'b1; rd_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_ready", 32'(rd_ready), 32'd0);
        chk("rst_we", 32'(bank_enable_write), 32'd0);
        chk("rst_re", 32'(bank_enable_read), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_a", rsp_data_a, 32'd0);
        chk("rst_addr", 32'(bank_address), 32'd0);
        chk("rst_in_data", bank_in_data, 32'd0);
        wr_valid = 1'b0; rd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].dual, vecs[i].a, vecs[i].b, vecs[i].da, vecs[i].db,
                         vecs[i].en, vecs[i].ea, vecs[i].eb, vecs[i].ed, vecs[i].edb);
            else
                do_read(vecs[i].a, vecs[i].b, vecs[i].ed, vecs[i].edb);
        end

        // Both requesters held valid: expect four write grants, then a read.
        wr_valid = 1'b1; wr_dual = 1'b0; wr_addr_a = 5'd10; wr_data_a = 32'h1000;
        rd_valid = 1'b1; rd_addr_a = 5'd10; rd_addr_b = 5'd0;
        n_grants = 0; n_rsp = 0; last_wr = '0; exp_rsp = '0;
        #1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            wgrant = 1'b0;
            if (rsp_valid) begin
                n_rsp++;
                chk("stream_rsp_a", rsp_data_a, exp_rsp);
                chk("stream_rsp_b", rsp_data_b, 32'h0);
            end
            if (wr_ready && rd_ready) chk("both_ready", 32'd1, 32'd0);
            if (wr_ready) begin
                last_wr = wr_data_a;
                wgrant = 1'b1;
                if (n_grants < 20) rec_rd[n_grants] = 1'b0;
                n_grants++;
            end
            if (rd_ready) begin
                exp_rsp = last_wr;
                if (n_grants < 20) rec_rd[n_grants] = 1'b1;
                n_grants++;
            end
            @(posedge clock); #1;
            if (wgrant) wr_data_a = wr_data_a + 32'd1;
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        chk("stream_grant_count_ge10", 32'(n_grants >= 10), 32'd1);
        chk("stream_rsp_count_ge2", 32'(n_rsp >= 2), 32'd1);
        for (int g = 0; g < 10; g++) begin
            if (g < n_grants) chk($sformatf("stream_grant%0d_is_rd", g),
                                  32'(rec_rd[g]), 32'((g % 5) == 4));
        end
        repeat (4) @(posedge clock);
        #1;

        // Reset during RD_ISSUE discards the read.
        rd_valid = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd0;
        #1;
        chk("mid_rd_ready", 32'(rd_ready), 32'd1);
        @(posedge clock); #1;
        rd_valid = 1'b0;
        chk("mid_rd_issue_re", 32'(bank_enable_read), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_re", 32'(bank_enable_read), 32'd0);
        chk("mid_rst_addr", 32'(bank_address), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_a", rsp_data_a, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        n_rsp = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clock); #1;
            if (rsp_valid) n_rsp++;
        end
        chk("mid_rst_no_rsp", 32'(n_rsp), 32'd0);
        do_read(5'd5, 5'd0, 32'hDEADBEEF, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/regbank_access_ctrl.md
Name: regbank_access_ctrl

Overview:
- Sequences all accesses to the dual-address 32x32 register bank.
- Arbitrates a writeback requester (one or two destination registers) against an operand-fetch requester (two source registers).
- Drives the bank's shared write/read enables, addresses and data, and returns read results with a one-cycle valid pulse.
- Enforces MIPS register-zero semantics and prevents reads from starving under continuous writeback.

Parameters:
DATA_WIDTH, 32, width of the register data path
ADDR_WIDTH, 5, width of the register address
MAX_WR_STREAK, 4, number of consecutive write grants allowed while a read waits

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted this cycle when high together with wr_valid
wr_dual  in  1  1: write both A and B; 0: write A only
wr_addr_a / wr_addr_b  in  ADDR_WIDTH  destination registers
wr_data_a / wr_data_b  in  DATA_WIDTH  write data
rd_valid  in  1  read request
rd_ready  out  1  read accepted this cycle when high together with rd_valid
rd_addr_a / rd_addr_b  in  ADDR_WIDTH  source registers
rsp_valid  out  1  one-cycle pulse: read data valid
rsp_data_a / rsp_data_b  out  DATA_WIDTH  read results
bank_address / bank_addressB  out  ADDR_WIDTH  to the bank's address ports
bank_enable_write / bank_enable_read  out  1  to the bank's enables
bank_in_data / bank_in_dataB  out  DATA_WIDTH  to the bank's write data ports
bank_out_data / bank_out_dataB  in  DATA_WIDTH  from the bank's outputs (high-Z while the bank is writing)

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; streak counter 0; captured addresses cleared.
  - All outputs 0, including bank_*, rsp_*, wr_ready and rd_ready.
  - Any request in flight is discarded without a response.
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_CAPTURE.
  - wr_ready and rd_ready are combinational and can be high only in IDLE.
  - At most one of wr_ready and rd_ready is high in any cycle.
- Arbitration in IDLE:
  - Only wr_valid: grant write.
  - Only rd_valid: grant read.
  - Both valid: grant write unless streak == MAX_WR_STREAK, in which case grant read.
- Streak counter (saturates at MAX_WR_STREAK):
  - Increments on each write grant made while rd_valid=1.
  - Clears on any read grant.
  - Clears in any IDLE cycle with rd_valid=0.
- Write grant at edge T:
  - Bank outputs are registered at T; state becomes WR_ISSUE; the bank writes at edge T+1; state returns to IDLE at T+1.
  - Both bank address ports are always driven, because the bank writes both ports.
  - Single write (wr_dual=0): drive both ports with (addr_a, data_a).
  - Dual write, addr_a == 0: drive both ports with B.
  - Dual write, addr_b == 0: drive both ports with A.
  - Dual write, addr_a == addr_b: drive both ports with B (B wins).
  - Every destination is register 0: handshake still completes and WR_ISSUE still takes one cycle, but bank_enable_write stays 0.
  - bank_enable_read = 0 during WR_ISSUE.
- Read grant at edge T:
  - At T: addresses registered, bank_enable_read=1, bank_enable_write=0, state RD_ISSUE.
  - At T+1: bank captures its output registers; bank_enable_read drops; state RD_CAPTURE.
  - At T+2: controller samples bank_out_data/B into rsp_data_a/b; rsp_valid=1 for the cycle after T+2; state IDLE.
  - Read latency: response valid 2 cycles after acceptance; throughput is one read per 3 cycles.
  - A captured address of 0 forces the corresponding rsp_data to 0, regardless of bank content.
  - rsp_data holds its value until the next capture.
- Read-after-write needs no bypass. A read accepted in the cycle after a write completes issues after the bank has written and returns the new value.
- Bank outputs are sampled only in RD_CAPTURE, where bank_enable_write=0, so high-Z values never propagate.
- No back-pressure on responses: the consumer must accept rsp_valid when it pulses.
- Reset asserted mid-read: no rsp_valid pulse after release; the first grant after release starts in IDLE.

Test Plan:
- Single write r5=0xDEADBEEF, then read (5,0) -> after write: bank_enable_write=1 for 1 cycle, both bank addresses=5; rsp_valid 2 cycles after read accept; rsp_data_a=0xDEADBEEF, rsp_data_b=0.
- Dual write r3=0x11, r0=0x22; read (3,0) -> bank ports both (3,0x11); rsp_data_a=0x11, rsp_data_b=0.
- Dual write r7=0xAA and r7=0xBB -> both ports (7,0xBB); read r7 returns 0xBB.
- Write and read held valid continuously -> exactly 4 write grants, then 1 read grant; pattern repeats; rsp returns correct values.
- Write r9=0x1234, then read r9 in the immediately following IDLE cycle -> rsp_data_a=0x1234 (RAW ordering).
- Assert reset during RD_ISSUE -> all outputs 0 immediately; no rsp_valid after release; a new read issued after release completes with 2-cycle latency.
